// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: drives data-memory transactions over a req/ack bus,
// steers store byte lanes, extends load data and registers the MEM/WB outputs.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_write_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stall_req_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_write_o,
    output logic [31:0] write_data_o,
    output logic        exc_misalign_o,
    output logic        exc_buserr_o,
    output logic [31:0] badvaddr_o
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [7:0]  cnt;
    logic [4:0]  lat_rd;
    logic [3:0]  lat_op;
    logic [1:0]  lat_off;
    logic        flushed;

    logic        is_load, is_store, is_mem, misaligned;
    logic [3:0]  sel;
    logic [31:0] wdata_lane;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        lat_is_load;
    logic        start, done, abort, stall;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        sel        = 4'b0000;
        wdata_lane = mem_wdata_i;
        case (mem_op_i)
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                sel     = 4'b1000 >> mem_addr_i[1:0];
            end
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                sel        = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                misaligned = mem_addr_i[0];
            end
            OP_LW: begin
                is_load    = 1'b1;
                sel        = 4'b1111;
                misaligned = |mem_addr_i[1:0];
            end
            OP_SB: begin
                is_store   = 1'b1;
                sel        = 4'b1000 >> mem_addr_i[1:0];
                wdata_lane = {4{mem_wdata_i[7:0]}};
            end
            OP_SH: begin
                is_store   = 1'b1;
                sel        = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                misaligned = mem_addr_i[0];
                wdata_lane = {2{mem_wdata_i[15:0]}};
            end
            OP_SW: begin
                is_store   = 1'b1;
                sel        = 4'b1111;
                misaligned = |mem_addr_i[1:0];
            end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    always_comb begin
        load_byte = bus_rdata_i[31:24];
        case (lat_off)
            2'd1:    load_byte = bus_rdata_i[23:16];
            2'd2:    load_byte = bus_rdata_i[15:8];
            2'd3:    load_byte = bus_rdata_i[7:0];
            default: load_byte = bus_rdata_i[31:24];
        endcase
        load_half = lat_off[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
        load_data = bus_rdata_i;
        case (lat_op)
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'd0, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'd0, load_half};
            default: load_data = bus_rdata_i;
        endcase
    end

    assign lat_is_load = (lat_op >= OP_LB) && (lat_op <= OP_LW);

    always_comb begin
        next_state = state;
        start      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i && !flush_i && is_mem && !misaligned) begin
                    start      = 1'b1;
                    stall      = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (bus_ack_i) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (cnt == LAST_WAIT) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign stall_req_o = stall && !rst;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= 8'd0;
            lat_rd         <= 5'd0;
            lat_op         <= 4'd0;
            lat_off        <= 2'd0;
            flushed        <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= 32'd0;
            bus_sel_o      <= 4'd0;
            bus_wdata_o    <= 32'd0;
            rd_addr_o      <= 5'd0;
            rd_write_o     <= 1'b0;
            write_data_o   <= 32'd0;
            exc_misalign_o <= 1'b0;
            exc_buserr_o   <= 1'b0;
            badvaddr_o     <= 32'd0;
        end else begin
            exc_misalign_o <= 1'b0;
            exc_buserr_o   <= 1'b0;
            if (state == IDLE) begin
                if (!valid_i || flush_i) begin
                    rd_write_o <= 1'b0;
                end else if (!is_mem) begin
                    rd_addr_o    <= rd_addr_i;
                    rd_write_o   <= rd_write_i;
                    write_data_o <= write_data_i;
                end else if (misaligned) begin
                    rd_write_o     <= 1'b0;
                    exc_misalign_o <= 1'b1;
                    badvaddr_o     <= mem_addr_i;
                end else if (start) begin
                    bus_req_o   <= 1'b1;
                    bus_we_o    <= is_store;
                    bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                    bus_sel_o   <= sel;
                    bus_wdata_o <= wdata_lane;
                    rd_write_o  <= 1'b0;
                    cnt         <= 8'd0;
                    lat_rd      <= rd_addr_i;
                    lat_op      <= mem_op_i;
                    lat_off     <= mem_addr_i[1:0];
                    flushed     <= 1'b0;
                end
            end else begin
                if (done) begin
                    bus_req_o <= 1'b0;
                    // A flush arriving in the ack cycle itself also kills the writeback.
                    if (lat_is_load && !flushed && !flush_i) begin
                        rd_write_o   <= 1'b1;
                        rd_addr_o    <= lat_rd;
                        write_data_o <= load_data;
                    end else begin
                        rd_write_o <= 1'b0;
                    end
                end else if (abort) begin
                    bus_req_o    <= 1'b0;
                    exc_buserr_o <= 1'b1;
                    badvaddr_o   <= {bus_addr_o[31:2], lat_off};
                    rd_write_o   <= 1'b0;
                end else begin
                    cnt <= cnt + 8'd1;
                    if (flush_i) flushed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: writeback expectations go through a scoreboard
// queue, every comparison is an immediate assertion.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i, rd_write_i, bus_ack_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] write_data_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
    logic [3:0]  mem_op_i;
    logic        bus_req_o, bus_we_o, stall_req_o, rd_write_o;
    logic        exc_misalign_o, exc_buserr_o;
    logic [31:0] bus_addr_o, bus_wdata_o, write_data_o, badvaddr_o;
    logic [3:0]  bus_sel_o;
    logic [4:0]  rd_addr_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .flush_i(flush_i),
        .rd_addr_i(rd_addr_i), .rd_write_i(rd_write_i), .write_data_i(write_data_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_req_o(stall_req_o),
        .rd_addr_o(rd_addr_o), .rd_write_o(rd_write_o), .write_data_o(write_data_o),
        .exc_misalign_o(exc_misalign_o), .exc_buserr_o(exc_buserr_o),
        .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i      = 1'b0;
        flush_i      = 1'b0;
        rd_addr_i    = 5'd0;
        rd_write_i   = 1'b0;
        write_data_i = 32'd0;
        mem_op_i     = 4'd0;
        mem_addr_i   = 32'd0;
        mem_wdata_i  = 32'd0;
        bus_ack_i    = 1'b0;
        bus_rdata_i  = 32'd0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] alu);
        valid_i      = 1'b1;
        flush_i      = 1'b0;
        mem_op_i     = op;
        mem_addr_i   = addr;
        mem_wdata_i  = wd;
        rd_addr_i    = rd;
        rd_write_i   = 1'b1;
        write_data_i = alu;
    endtask

    task automatic expect_wb(input string tag);
        wb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, observed rd_write_o=%0b", tag, rd_write_o);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_we"}, 32'(rd_write_o), 32'(e.we));
        if (e.we) begin
            check({tag, "_rd"}, 32'(rd_addr_o), 32'(e.rd));
            check({tag, "_data"}, write_data_o, e.data);
        end
    endtask

    // One aligned bus transaction: issue, `waits` un-acked REQ cycles, then ack.
    task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd, input int waits,
                           input logic [31:0] rdata, input logic [3:0] exp_sel,
                           input logic exp_we, input logic [31:0] exp_wdata,
                           input logic exp_wb, input logic [31:0] exp_data, input bit flush_req1);
        int stall_cycles;
        stall_cycles = 0;
        sb_q.push_back('{rd: rd, we: exp_wb, data: exp_data});
        drive(op, addr, wd, rd, 32'h0000_DEAD);
        #1;
        check({tag, "_stall_idle"}, 32'(stall_req_o), 32'd1);
        if (stall_req_o) stall_cycles++;
        tick();
        check({tag, "_req"}, 32'(bus_req_o), 32'd1);
        check({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
        check({tag, "_sel"}, 32'(bus_sel_o), 32'(exp_sel));
        check({tag, "_we"}, 32'(bus_we_o), 32'(exp_we));
        if (exp_we) check({tag, "_wdata"}, bus_wdata_o, exp_wdata);
        check({tag, "_wb_off"}, 32'(rd_write_o), 32'd0);
        for (int i = 0; i < waits; i++) begin
            flush_i = flush_req1 && (i == 0);
            #1;
            if (stall_req_o) stall_cycles++;
            tick();
            flush_i = 1'b0;
            check({tag, "_req_hold"}, 32'(bus_req_o), 32'd1);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = rdata;
        #1;
        check({tag, "_stall_ack"}, 32'(stall_req_o), 32'd0);
        tick();
        idle_inputs();
        check({tag, "_req_fall"}, 32'(bus_req_o), 32'd0);
        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(waits + 1));
        expect_wb(tag);
    endtask

    initial begin
        int req_cycles;
        idle_inputs();
        rst = 1'b1;
        drive(4'd5, 32'h0000_0100, 32'd0, 5'd1, 32'd0);
        #1;
        check("rst_stall", 32'(stall_req_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_wb", 32'(rd_write_o), 32'd0);
        check("rst_data", write_data_o, 32'd0);
        check("rst_badv", badvaddr_o, 32'd0);
        tick();
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();

        // Non-memory op: one-cycle latency.
        drive(4'd0, 32'h0, 32'h0, 5'd5, 32'h0000_00F0);
        sb_q.push_back('{rd: 5'd5, we: 1'b1, data: 32'h0000_00F0});
        #1;
        check("alu_stall", 32'(stall_req_o), 32'd0);
        tick();
        idle_inputs();
        expect_wb("alu");
        check("alu_no_req", 32'(bus_req_o), 32'd0);

        mem_txn("lb",  4'd1, 32'h0000_1001, 32'h0, 5'd7, 2, 32'h1280_3456, 4'b0100, 1'b0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
        mem_txn("lbu", 4'd2, 32'h0000_1001, 32'h0, 5'd8, 2, 32'h1280_3456, 4'b0100, 1'b0, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
        mem_txn("sh",  4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 5'd9, 1, 32'h0, 4'b0011, 1'b1, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0);
        mem_txn("lh",  4'd3, 32'h0000_4000, 32'h0, 5'd10, 0, 32'h8001_7777, 4'b1100, 1'b0, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
        mem_txn("lhu", 4'd4, 32'h0000_4002, 32'h0, 5'd11, 0, 32'h1234_F00D, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h0000_F00D, 1'b0);
        mem_txn("lb3", 4'd1, 32'h0000_4003, 32'h0, 5'd12, 1, 32'h8080_807F, 4'b0001, 1'b0, 32'h0, 1'b1, 32'h0000_007F, 1'b0);
        mem_txn("sb",  4'd6, 32'h0000_5003, 32'h1234_56A5, 5'd13, 0, 32'h0, 4'b0001, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
        mem_txn("sw",  4'd8, 32'h0000_6000, 32'hCAFE_BABE, 5'd14, 3, 32'h0, 4'b1111, 1'b1, 32'hCAFE_BABE, 1'b0, 32'h0, 1'b0);
        mem_txn("lw",  4'd5, 32'h0000_7000, 32'h0, 5'd15, 1, 32'h89AB_CDEF, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h89AB_CDEF, 1'b0);
        mem_txn("lw_flush", 4'd5, 32'h0000_7004, 32'h0, 5'd16, 1, 32'h1111_2222, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Misaligned LW: fault pulse, no bus access, no stall.
        drive(4'd5, 32'h0000_3002, 32'h0, 5'd17, 32'h0);
        sb_q.push_back('{rd: 5'd17, we: 1'b0, data: 32'h0});
        #1;
        check("mis_stall", 32'(stall_req_o), 32'd0);
        tick();
        idle_inputs();
        check("mis_no_req", 32'(bus_req_o), 32'd0);
        check("mis_pulse", 32'(exc_misalign_o), 32'd1);
        check("mis_badv", badvaddr_o, 32'h0000_3002);
        expect_wb("mis");
        tick();
        check("mis_pulse_end", 32'(exc_misalign_o), 32'd0);
        check("mis_badv_hold", badvaddr_o, 32'h0000_3002);

        // Timeout: ack never comes.
        drive(4'd5, 32'h0000_8000, 32'h0, 5'd18, 32'h0);
        sb_q.push_back('{rd: 5'd18, we: 1'b0, data: 32'h0});
        tick();
        req_cycles = 0;
        while (bus_req_o && req_cycles < 20) begin
            check("to_stall", 32'(stall_req_o), (req_cycles == TO - 1) ? 32'd0 : 32'd1);
            check("to_no_pulse", 32'(exc_buserr_o), 32'd0);
            req_cycles++;
            tick();
        end
        idle_inputs();
        check("to_req_cycles", 32'(req_cycles), 32'(TO));
        check("to_pulse", 32'(exc_buserr_o), 32'd1);
        check("to_badv", badvaddr_o, 32'h0000_8000);
        expect_wb("to");
        tick();
        check("to_pulse_end", 32'(exc_buserr_o), 32'd0);

        // Ack while idle is ignored.
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        check("idle_ack_req", 32'(bus_req_o), 32'd0);
        check("idle_ack_wb", 32'(rd_write_o), 32'd0);

        // Reset mid-REQ drops the request immediately.
        drive(4'd5, 32'h0000_9000, 32'h0, 5'd19, 32'h0);
        tick();
        check("rreq_req", 32'(bus_req_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rreq_drop", 32'(bus_req_o), 32'd0);
        check("rreq_stall", 32'(stall_req_o), 32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        check("rreq_idle_req", 32'(bus_req_o), 32'd0);
        check("rreq_no_fault", 32'(exc_buserr_o), 32'd0);
        check("rreq_wb", 32'(rd_write_o), 32'd0);

        drive(4'd0, 32'h0, 32'h0, 5'd3, 32'h0BAD_F00D);
        sb_q.push_back('{rd: 5'd3, we: 1'b1, data: 32'h0BAD_F00D});
        #1;
        check("post_rst_stall", 32'(stall_req_o), 32'd0);
        tick();
        idle_inputs();
        expect_wb("post_rst");
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
